// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: register map, CTRL bit positions and byte-lane merge shared by the counter block
package multi_counter_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_LIMIT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_DOWN    = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IRQ_EN  = 3;
    localparam int CH_LSB  = 4;
    localparam int CH_MSB  = 7;
    localparam int REG_LSB = 2;
    localparam int REG_MSB = 3;
    function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                               input logic [3:0] sel);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : cur[8*i +: 8];
        return res;
    endfunction
endpackage

// File: rtl/multi_counter_wb_channel.sv
// counter_channel: one up/down counter with limit/reload, one-shot mode, sticky match and irq enable
//   clk, rst_n      clock, async active-low reset
//   wr              accepted bus write aimed at this channel
//   reg_sel         register offset (CTRL/COUNT/LIMIT/STATUS)
//   sel, wdat       byte lanes and write data
//   rdat            zero-extended read value of the selected register
//   count, match    current count and sticky match flag
//   irq             match gated by IRQ_EN
module counter_channel
    import multi_counter_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr,
    input  logic [1:0]      reg_sel,
    input  logic [3:0]      sel,
    input  logic [31:0]     wdat,
    output logic [31:0]     rdat,
    output logic [BITS-1:0] count,
    output logic            match,
    output logic            irq
);
    logic [BITS-1:0] limit, count_n, limit_n;
    logic [3:0] ctrl, ctrl_n;
    logic ctrl_wr, count_wr, limit_wr, clr, tick, at_end, fire, match_n;

    always_comb begin
        ctrl_wr  = wr & (reg_sel == REG_CTRL) & sel[0];
        count_wr = wr & (reg_sel == REG_COUNT);
        limit_wr = wr & (reg_sel == REG_LIMIT);
        clr      = wr & (reg_sel == REG_STATUS) & sel[0] & wdat[0];
        // a COUNT write or a CTRL write clearing EN suppresses this cycle's tick
        tick     = ctrl[CTRL_EN] & ~count_wr & ~(ctrl_wr & ~wdat[CTRL_EN]);
        at_end   = ctrl[CTRL_DOWN] ? (count == '0) : (count == limit);
        fire     = tick & at_end;
        count_n  = count_wr ? BITS'(byte_merge(32'(count), wdat, sel)) :
                   !tick ? count :
                   at_end ? (ctrl[CTRL_ONESHOT] ? count : ctrl[CTRL_DOWN] ? limit : '0) :
                   ctrl[CTRL_DOWN] ? count - 1'b1 : count + 1'b1;
        limit_n  = limit_wr ? BITS'(byte_merge(32'(limit), wdat, sel)) : limit;
        ctrl_n   = ctrl_wr ? wdat[3:0] : ctrl;
        if (fire & ctrl[CTRL_ONESHOT]) ctrl_n[CTRL_EN] = 1'b0;
        // a new match beats a coincident write-1-to-clear
        match_n  = fire | (match & ~clr);
        rdat     = (reg_sel == REG_CTRL)  ? {28'd0, ctrl} :
                   (reg_sel == REG_COUNT) ? 32'(count) :
                   (reg_sel == REG_LIMIT) ? 32'(limit) : {31'd0, match};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            limit <= '1;
            ctrl  <= '0;
            match <= 1'b0;
        end else begin
            count <= count_n;
            limit <= limit_n;
            ctrl  <= ctrl_n;
            match <= match_n;
        end
    end

    assign irq = match & ctrl[CTRL_IRQ_EN];
endmodule

// File: rtl/multi_counter_wb.sv
// multi_counter_wb: NUM_CH Wishbone-controlled counter channels with combined interrupt
//   wb_clk_i, wb_rst_ni   clock, async active-low reset
//   wbs_*                 Wishbone slave, decoded on adr[31:8]; ch = adr[7:4], reg = adr[3:2]
//   count_o               flattened counts, ch0 in LSBs
//   match_o               sticky match flags
//   irq_o                 OR of match & IRQ_EN over channels
module multi_counter_wb
    import multi_counter_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          BITS     = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NUM_CH*BITS-1:0] count_o,
    output logic [NUM_CH-1:0]      match_o,
    output logic                   irq_o
);
    logic ack, valid, accept, unused_adr;
    logic [3:0] ch;
    logic [1:0] reg_sel;
    logic [31:0] rdat [16];
    logic [NUM_CH-1:0] irq_all;

    assign ch         = wbs_adr_i[CH_MSB:CH_LSB];
    assign reg_sel    = wbs_adr_i[REG_MSB:REG_LSB];
    assign valid      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // the ack cycle never accepts, forcing one idle cycle between transfers
    assign accept     = valid & ~ack;
    assign wbs_ack_o  = ack;
    assign irq_o      = |irq_all;
    assign unused_adr = ^wbs_adr_i[1:0];

    // slots beyond NUM_CH read as zero, so out-of-range channels ack with data 0
    for (genvar g = 0; g < 16; g++) begin : g_ch
        if (g < NUM_CH) begin : g_on
            counter_channel #(.BITS(BITS)) u_ch (
                .clk    (wb_clk_i),
                .rst_n  (wb_rst_ni),
                .wr     (accept & wbs_we_i & (ch == 4'(g))),
                .reg_sel(reg_sel),
                .sel    (wbs_sel_i),
                .wdat   (wbs_dat_i),
                .rdat   (rdat[g]),
                .count  (count_o[g*BITS +: BITS]),
                .match  (match_o[g]),
                .irq    (irq_all[g])
            );
        end else begin : g_off
            assign rdat[g] = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack       <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            ack <= accept;
            if (accept & ~wbs_we_i) wbs_dat_o <= rdat[ch];
        end
    end
endmodule

// File: tb/tb_multi_counter_wb.sv
// tb_multi_counter_wb: directed and random Wishbone traffic checked against a per-cycle channel model
module tb_multi_counter_wb;
    localparam int NUM_CH = 4;
    localparam int BITS = 32;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0, rst_n = 1'b0;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0] sel = '0;
    logic [31:0] adr = '0, dat_i = '0;
    logic ack;
    logic [31:0] dat_o;
    logic [NUM_CH*BITS-1:0] count_o;
    logic [NUM_CH-1:0] match_o;
    logic irq;

    multi_counter_wb #(.NUM_CH(NUM_CH), .BITS(BITS), .BASE_ADR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .count_o  (count_o),
        .match_o  (match_o),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [3:0]  m_ctrl [NUM_CH];
    logic [31:0] m_count [NUM_CH];
    logic [31:0] m_limit [NUM_CH];
    logic        m_match [NUM_CH];
    logic [31:0] m_rd;
    bit prev_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] adr_of(input int ch, input int r);
        return BASE | 32'(ch << 4) | 32'(r << 2);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) if (s[b]) res[8*b +: 8] = d[8*b +: 8];
        return res;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_ctrl[c] = '0;
            m_count[c] = '0;
            m_limit[c] = '1;
            m_match[c] = 1'b0;
        end
        m_rd = '0;
        prev_acc = 0;
    endtask

    // one clock edge of the whole block: bus access first resolved, then every channel advanced
    task automatic model_edge(input bit acc, input bit w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d);
        int ch, r;
        bit wc, runs, fired, dn, os;
        ch = int'(a[7:4]);
        r = int'(a[3:2]);
        if (acc && !w)
            m_rd = (ch >= NUM_CH) ? 32'd0 : r == 0 ? {28'd0, m_ctrl[ch]} : r == 1 ? m_count[ch] :
                   r == 2 ? m_limit[ch] : {31'd0, m_match[ch]};
        for (int c = 0; c < NUM_CH; c++) begin
            wc = acc && w && (c == ch);
            dn = m_ctrl[c][1];
            os = m_ctrl[c][2];
            fired = 0;
            runs = m_ctrl[c][0] && !(wc && r == 1) && !(wc && r == 0 && s[0] && !d[0]);
            if (runs) begin
                if (dn ? (m_count[c] == 0) : (m_count[c] == m_limit[c])) begin
                    fired = 1;
                    if (!os) m_count[c] = dn ? m_limit[c] : 32'd0;
                end else begin
                    m_count[c] = dn ? m_count[c] - 1 : m_count[c] + 1;
                end
            end
            if (wc && r == 1) m_count[c] = lanes(m_count[c], d, s);
            if (wc && r == 2) m_limit[c] = lanes(m_limit[c], d, s);
            if (wc && r == 0 && s[0]) m_ctrl[c] = d[3:0];
            if (fired && os) m_ctrl[c][0] = 1'b0;
            m_match[c] = fired || (m_match[c] && !(wc && r == 3 && s[0] && d[0]));
        end
    endtask

    task automatic step(input bit bus, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
        bit acc, irq_exp;
        logic [NUM_CH-1:0] mexp;
        stb = bus; cyc = bus; we = w; adr = a; sel = s; dat_i = d;
        @(posedge clk);
        acc = bus && (a[31:8] == BASE[31:8]) && !prev_acc;
        prev_acc = acc;
        model_edge(acc, w, a, s, d);
        #1;
        irq_exp = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            mexp[c] = m_match[c];
            irq_exp |= m_match[c] & m_ctrl[c][3];
            check($sformatf("count%0d", c), count_o[32*c +: 32], m_count[c]);
        end
        check("ack", 32'(ack), 32'(acc));
        check("rdata", dat_o, m_rd);
        check("match", 32'(match_o), 32'(mexp));
        check("irq", 32'(irq), 32'(irq_exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, BASE, 4'h0, 32'd0);
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        step(1, 1, adr_of(ch, r), 4'hF, d);
        idle(1);
    endtask

    initial begin
        logic [31:0] a, d;
        int ch, r;
        model_reset();
        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_cnt", 32'(|count_o), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 4; k++) begin
                step(1, 0, adr_of(c, k), 4'h0, 32'd0);
                check("rst_reg", dat_o, k == 2 ? 32'hFFFF_FFFF : 32'd0);
                idle(1);
            end

        wr(1, 2, 32'd5);
        step(1, 1, adr_of(1, 0), 4'hF, 32'h9);
        check("ch1_seq", count_o[63:32], 32'd0);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            check("ch1_seq", count_o[63:32], 32'(k % 6));
            check("ch1_match", 32'(match_o[1]), 32'(k == 6));
            check("ch1_irq", 32'(irq), 32'(k == 6));
        end
        step(1, 1, adr_of(1, 3), 4'h1, 32'd1);
        check("w1c_irq", 32'(irq), 32'd0);
        idle(1);
        wr(1, 0, 32'h1);
        idle(8);
        check("noirq_match", 32'(match_o[1]), 32'd1);
        check("noirq_irq", 32'(irq), 32'd0);

        wr(2, 2, 32'd3);
        wr(2, 1, 32'd3);
        step(1, 1, adr_of(2, 0), 4'hF, 32'h7);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            check("ch2_down", count_o[95:64], 32'(k >= 3 ? 0 : 3 - k));
        end
        step(1, 0, adr_of(2, 0), 4'h0, 32'd0);
        check("ch2_ctrl", dat_o, 32'h6);
        idle(1);
        step(1, 0, adr_of(2, 3), 4'h0, 32'd0);
        check("ch2_status", dat_o, 32'd1);
        idle(1);

        step(1, 1, adr_of(0, 0), 4'hF, 32'h1);
        idle(5);
        step(1, 1, adr_of(0, 1), 4'b0010, 32'h100);
        check("lane_wr", count_o[31:0], 32'h105);
        idle(1);
        step(1, 0, adr_of(0, 1), 4'h0, 32'd0);
        check("lane_rd", dat_o, 32'h106);
        idle(1);

        wr(3, 2, 32'd2);
        step(1, 1, adr_of(3, 0), 4'hF, 32'h1);
        idle(2);
        step(1, 1, adr_of(3, 3), 4'h1, 32'd1);
        check("coinc_match", 32'(match_o[3]), 32'd1);
        idle(1);
        check("coinc_hold", 32'(match_o[3]), 32'd1);

        step(1, 0, adr_of(NUM_CH, 1), 4'h0, 32'd0);
        check("oor_ack", 32'(ack), 32'd1);
        check("oor_dat", dat_o, 32'd0);
        idle(1);
        wr(NUM_CH, 2, 32'd7);
        step(1, 0, BASE + 32'h100, 4'h0, 32'd0);
        check("miss_ack", 32'(ack), 32'd0);
        idle(1);

        for (int i = 0; i < 1500; i++) begin
            ch = $urandom_range(0, NUM_CH);
            r = $urandom_range(0, 3);
            a = adr_of(ch, r);
            if ($urandom_range(0, 15) == 0) a = a ^ 32'h0000_1000;
            d = r == 0 ? $urandom : r == 3 ? 32'($urandom_range(0, 1)) : 32'($urandom_range(0, 12));
            step($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d);
        end

        wr(0, 0, 32'h1);
        idle(3);
        step(1, 0, adr_of(0, 1), 4'h0, 32'd0);
        check("pre_rst_ack", 32'(ack), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_ack", 32'(ack), 32'd0);
        check("async_dat", dat_o, 32'd0);
        check("async_cnt", 32'(|count_o), 32'd0);
        check("async_match", 32'(match_o), 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("post_rst_idle", 32'(|count_o), 32'd0);
        step(1, 1, adr_of(1, 0), 4'hF, 32'h1);
        idle(3);
        check("post_rst_run", count_o[63:32], 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_counter_wb.md
Name: multi_counter_wb

Overview:
- Parametrised successor to the single-channel user-project counter.
- NUM_CH independent BITS-wide counter channels, each with:
  - up or down direction
  - programmable limit/reload
  - periodic or one-shot mode
  - sticky match flag
  - per-channel interrupt enable
- Controlled by a Wishbone slave in the user area.
- Flattened count vector drives GPIO/LA; a combined interrupt drives one irq line.

Parameters:
- NUM_CH, 4, number of counter channels (1..16)
- BITS, 32, counter width per channel (1..32); register reads zero-extended to 32
- BASE_ADR, 32'h3000_0000, Wishbone base address; decoded on wbs_adr_i[31:8]

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- count_o  out  NUM_CH*BITS  channel counts; ch0 in LSBs
- match_o  out  NUM_CH  sticky match flags
- irq_o  out  1  OR over channels of (match & irq_en)

Behaviour:
- Reset (wb_rst_ni low, async): all state cleared.
  - Outputs: count_o=0, match_o=0, irq_o=0, wbs_ack_o=0, wbs_dat_o=0.
  - Per channel: CTRL=0, LIMIT=all-ones.
- Address decode, only when wbs_adr_i[31:8] equals BASE_ADR[31:8]:
  - Channel index = adr[7:4]; register = adr[3:2].
  - 0 CTRL: bit0 EN, bit1 DOWN, bit2 ONESHOT, bit3 IRQ_EN; other bits read 0.
  - 1 COUNT
  - 2 LIMIT
  - 3 STATUS: bit0 MATCH, write-1-to-clear.
- Handshake:
  - valid = cyc & stb & address hit.
  - ack pulses high exactly one cycle, the cycle after the first valid cycle; the next cycle is a forced idle (ack low), so back-to-back transfers take 2 cycles each.
  - wbs_dat_o is registered alongside ack and holds until the next read.
  - Address miss: no ack. Leaves the bus to the user-area decoder.
- Out-of-range channel (index >= NUM_CH): acked, reads 0, writes ignored.
- Writes:
  - COUNT/LIMIT honour wbs_sel_i byte lanes; bytes above BITS are dropped.
  - CTRL uses byte 0 only.
  - Write to a read-only or undefined bit has no effect.
- Counting, per cycle while EN=1:
  - Up: if count==LIMIT then MATCH<=1 and count<=0; else count+1.
  - Down: if count==0 then MATCH<=1 and count<=LIMIT; else count-1.
  - ONESHOT: on the match event EN<=0 and count holds the terminal value (up: LIMIT; down: 0).
  - LIMIT=0 in up mode: match every cycle, count stays 0.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the bus write wins; no tick that cycle.
  - Bus write to CTRL clearing EN: takes effect that cycle; no tick.
  - STATUS W1C coincident with a new match: set wins, MATCH stays 1.
  - Write to LIMIT: takes effect on the next compare cycle.
- irq_o is combinational from registered state; no glitch path from bus inputs.
- Reset asserted mid-transaction: ack drops immediately; the transfer is lost and the master retries.

Decomposition:
- Shared package multi_counter_pkg:
  - register offsets REG_CTRL/REG_COUNT/REG_LIMIT/REG_STATUS
  - CTRL bit indices
  - channel-field address slice constants
- One sub-module counter_channel (parameter BITS) contains:
  - the count, limit, CTRL and MATCH registers
  - tick/compare/reload logic
  - byte-lane write merge
- Top level contains the Wishbone decode, ack/read mux, generate loop over NUM_CH, and IRQ reduction.

Test Plan:
- Reset, then read every register of ch0..NUM_CH-1 -> CTRL=0, COUNT=0, LIMIT=32'hFFFF_FFFF, STATUS=0; irq_o=0.
- ch1: LIMIT=5, CTRL=0x9 (EN, IRQ_EN, up, periodic) -> count sequence 0,1,2,3,4,5,0; MATCH and irq_o rise on the cycle count wraps 5->0; W1C STATUS=1 clears irq_o. Keep irq_o low by first clearing IRQ_EN: MATCH still set, irq_o stays 0.
- ch2: LIMIT=3, COUNT=3, CTRL=0x7 (EN, DOWN, ONESHOT) -> 3,2,1,0 then holds 0; CTRL reads 0x6 (EN cleared); MATCH=1.
- ch0: running up, write COUNT=0x100 with sel=4'b0010 -> next COUNT read shows only byte1 replaced; the write cycle produces no increment.
- Coincidence: W1C STATUS on the exact match cycle -> MATCH remains 1. Access to channel NUM_CH -> ack after 1 cycle, data 0, no state change.
- Assert wb_rst_ni low mid-count with a pending transfer -> all outputs 0 asynchronously, no ack; counting resumes only after software re-enables.
